// File: rtl/mcp3008_spi_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mcp3008_spi_master_if
// Brief    : Request/result bus between a client and the MCP3008 SPI master.
// Revision : 1.0
// ============================================================================
interface mcp3008_spi_master_if;
    logic       start;
    logic [2:0] channel;
    logic       busy;
    logic       data_valid;
    logic [9:0] out_data;
    logic [2:0] out_channel;
    logic       null_err;

    modport master (
        output start, channel,
        input  busy, data_valid, out_data, out_channel, null_err
    );

    modport slave (
        input  start, channel,
        output busy, data_valid, out_data, out_channel, null_err
    );
endinterface
`default_nettype wire

// File: rtl/mcp3008_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mcp3008_spi_master
// Brief    : Mode-0 SPI master running one 17-sclk MCP3008 conversion per start.
// Revision : 1.0
// ============================================================================
module mcp3008_spi_master #(
    parameter int unsigned CLK_DIV = 25,
    parameter bit          SGL     = 1'b1
) (
    input  wire logic                 clk_50M,
    input  wire logic                 rst,
    mcp3008_spi_master_if.slave       bus,
    output logic                      sclk,
    output logic                      MOSI,
    input  wire logic                 MISO,
    output logic                      CE_N
);

    localparam logic [8:0] c_HALF_LAST   = 9'(CLK_DIV - 1);
    localparam logic [8:0] c_HOLD_LAST   = 9'(2 * CLK_DIV - 1);
    localparam logic [4:0] c_NULL_PERIOD = 5'd7;
    localparam logic [4:0] c_LAST_PERIOD = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t     r_state;
    logic [8:0] r_cnt;
    logic [4:0] r_period;
    logic [2:0] r_cmd;
    logic [8:0] r_shift;
    logic       r_null_cap;
    logic       r_miso_meta;
    logic       r_miso_sync;
    logic       r_busy;
    logic       r_data_valid;
    logic [9:0] r_out_data;
    logic [2:0] r_out_channel;
    logic       r_null_err;

    // Command bit presented on MOSI during sclk period p (1-based).
    function automatic logic cmd_bit(input logic [4:0] p, input logic [2:0] ch);
        case (p)
            5'd1:    return 1'b1;
            5'd2:    return SGL;
            5'd3:    return ch[2];
            5'd4:    return ch[1];
            5'd5:    return ch[0];
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_period      <= '0;
            r_cmd         <= '0;
            r_shift       <= '0;
            r_null_cap    <= 1'b0;
            r_miso_meta   <= 1'b0;
            r_miso_sync   <= 1'b0;
            r_busy        <= 1'b0;
            r_data_valid  <= 1'b0;
            r_out_data    <= '0;
            r_out_channel <= '0;
            r_null_err    <= 1'b0;
            sclk          <= 1'b0;
            MOSI          <= 1'b0;
            CE_N          <= 1'b1;
        end else begin
            r_miso_meta  <= MISO;
            r_miso_sync  <= r_miso_meta;
            r_data_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cmd      <= bus.channel;
                        r_cnt      <= '0;
                        r_period   <= 5'd1;
                        r_shift    <= '0;
                        r_null_cap <= 1'b0;
                        r_busy     <= 1'b1;
                        CE_N       <= 1'b0;
                        sclk       <= 1'b0;
                        MOSI       <= 1'b1;
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (r_cnt != c_HALF_LAST) begin
                        r_cnt <= r_cnt + 9'd1;
                    end else begin
                        r_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // Last cycle of a high half: sample, then start the next period.
                            if (r_period == c_NULL_PERIOD) begin
                                r_null_cap <= r_miso_sync;
                            end else if (r_period > c_NULL_PERIOD && r_period < c_LAST_PERIOD) begin
                                r_shift <= {r_shift[7:0], r_miso_sync};
                            end
                            sclk <= 1'b0;
                            if (r_period == c_LAST_PERIOD) begin
                                CE_N          <= 1'b1;
                                MOSI          <= 1'b0;
                                r_data_valid  <= 1'b1;
                                r_out_data    <= {r_shift, r_miso_sync};
                                r_out_channel <= r_cmd;
                                r_null_err    <= r_null_cap;
                                r_state       <= S_HOLD;
                            end else begin
                                r_period <= r_period + 5'd1;
                                MOSI     <= cmd_bit(r_period + 5'd1, r_cmd);
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt != c_HOLD_LAST) begin
                        r_cnt <= r_cnt + 9'd1;
                    end else begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.data_valid  = r_data_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_channel = r_out_channel;
    assign bus.null_err    = r_null_err;

endmodule
`default_nettype wire

// File: tb/tb_mcp3008_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mcp3008_spi_master
// Brief    : Directed bench with MCP3008 behavioural models for two DUT builds.
// Revision : 1.0
// ============================================================================
module tb_mcp3008_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int dvc0     = 0;

    mcp3008_spi_master_if bus0();
    mcp3008_spi_master_if bus1();

    logic [1:0] sclk_v, mosi_v, ce_v, miso_v;
    logic [1:0] mnull, mzero;
    logic [9:0] val_tbl [8];

    mcp3008_spi_master #(.CLK_DIV(25), .SGL(1'b1)) u_dut0 (
        .clk_50M(clk), .rst(rst), .bus(bus0),
        .sclk(sclk_v[0]), .MOSI(mosi_v[0]), .MISO(miso_v[0]), .CE_N(ce_v[0])
    );

    mcp3008_spi_master #(.CLK_DIV(4), .SGL(1'b0)) u_dut1 (
        .clk_50M(clk), .rst(rst), .bus(bus1),
        .sclk(sclk_v[1]), .MOSI(mosi_v[1]), .MISO(miso_v[1]), .CE_N(ce_v[1])
    );

    always @(posedge clk) if (bus0.data_valid) dvc0 <= dvc0 + 1;

    // ADC model: decodes the command from MOSI and returns its table word after falls.
    for (genvar g = 0; g < 2; g++) begin : g_adc
        logic       prev_sclk = 1'b0;
        logic       prev_ce   = 1'b1;
        logic       miso_m    = 1'b0;
        int         rises = 0, falls = 0, frame_rises = 0, rise1 = 0, rise2 = 0;
        logic [4:0] bits = '0;
        logic [9:0] word;
        assign word      = mzero[g] ? 10'h000 : val_tbl[bits[2:0]];
        assign miso_v[g] = miso_m;
        always @(posedge clk) begin
            prev_sclk <= sclk_v[g];
            prev_ce   <= ce_v[g];
            if (prev_ce && !ce_v[g]) begin
                rises  <= 0;
                falls  <= 0;
                bits   <= '0;
                miso_m <= 1'b0;
            end else if (!ce_v[g]) begin
                if (sclk_v[g] && !prev_sclk) begin
                    rises <= rises + 1;
                    if (rises < 5) bits <= {bits[3:0], mosi_v[g]};
                    if (rises == 0) rise1 <= cyc;
                    if (rises == 1) rise2 <= cyc;
                end
                if (!sclk_v[g] && prev_sclk) begin
                    falls <= falls + 1;
                    if (falls == 5) miso_m <= mnull[g];
                    else if (falls >= 6 && falls <= 15) miso_m <= word[15 - falls];
                end
            end
            if (!prev_ce && ce_v[g]) frame_rises <= rises;
        end
    end

    function automatic logic dv_of(input int i);
        return (i == 0) ? bus0.data_valid : bus1.data_valid;
    endfunction

    function automatic logic busy_of(input int i);
        return (i == 0) ? bus0.busy : bus1.busy;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_dv(input int i, input int budget, output int t);
        int n = 0;
        while (dv_of(i) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("dv_seen", 32'(dv_of(i)), 32'd1);
        t = cyc;
    endtask

    task automatic wait_idle(input int i, input int budget, output int t);
        int n = 0;
        while (busy_of(i) !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_seen", 32'(busy_of(i)), 32'd0);
        t = cyc;
    endtask

    task automatic pulse_start0(input logic [2:0] ch, output int t0);
        bus0.start   = 1'b1;
        bus0.channel = ch;
        t0 = cyc;
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t, tb, tprev, snap, n;
        val_tbl = '{10'h0C3, 10'h11E, 10'h200, 10'h155, 10'h07F, 10'h2A5, 10'h381, 10'h3FF};
        mnull = 2'b00;
        mzero = 2'b00;
        bus0.start = 1'b0; bus0.channel = 3'd0;
        bus1.start = 1'b0; bus1.channel = 3'd0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     32'(bus0.busy),        32'd0);
        chk("rst_dv",       32'(bus0.data_valid),  32'd0);
        chk("rst_data",     32'(bus0.out_data),    32'd0);
        chk("rst_chan",     32'(bus0.out_channel), 32'd0);
        chk("rst_null",     32'(bus0.null_err),    32'd0);
        chk("rst_sclk",     32'(sclk_v[0]),        32'd0);
        chk("rst_mosi",     32'(mosi_v[0]),        32'd0);
        chk("rst_ce",       32'(ce_v[0]),          32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single conversion on channel 5.
        pulse_start0(3'd5, t0);
        wait_dv(0, 2000, t);
        chk("single_latency", 32'(t - t0),           32'd851);
        chk("single_data",    32'(bus0.out_data),    32'h2A5);
        chk("single_chan",    32'(bus0.out_channel), 32'd5);
        chk("single_null",    32'(bus0.null_err),    32'd0);
        chk("single_ce_high", 32'(ce_v[0]),          32'd1);
        chk("single_cmd",     32'(g_adc[0].bits),    32'b11101);
        @(negedge clk);
        chk("single_pulse",   32'(bus0.data_valid),  32'd0);
        chk("single_rises",   32'(g_adc[0].frame_rises), 32'd17);
        wait_idle(0, 200, tb);
        chk("single_busy",    32'(tb - t0),          32'd901);
        chk("single_hold",    32'(tb - t),           32'd50);
        chk("single_ce_end",  32'(ce_v[0]),          32'd1);

        // Back-to-back frames with start held, channel stepping 0..7.
        bus0.channel = 3'd0;
        bus0.start   = 1'b1;
        tprev = 0;
        for (int f = 0; f < 8; f++) begin
            wait_dv(0, 1200, t);
            chk("b2b_data", 32'(bus0.out_data),    32'(val_tbl[f]));
            chk("b2b_chan", 32'(bus0.out_channel), 32'(f));
            if (f > 0) chk("b2b_spacing", 32'(t - tprev), 32'd901);
            tprev = t;
            if (f < 7) bus0.channel = 3'(f + 1);
            else       bus0.start   = 1'b0;
            @(negedge clk);
            chk("b2b_pulse", 32'(bus0.data_valid),        32'd0);
            chk("b2b_rises", 32'(g_adc[0].frame_rises),   32'd17);
        end
        wait_idle(0, 200, tb);

        // Start and channel changes mid-frame are ignored.
        snap = dvc0;
        pulse_start0(3'd6, t0);
        repeat (300) @(negedge clk);
        bus0.start   = 1'b1;
        bus0.channel = 3'd2;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_dv(0, 1000, t);
        chk("mid_chan", 32'(bus0.out_channel), 32'd6);
        chk("mid_data", 32'(bus0.out_data),    32'h381);
        wait_idle(0, 200, tb);
        repeat (20) @(negedge clk);
        chk("mid_no_restart_busy", 32'(bus0.busy), 32'd0);
        chk("mid_no_restart_ce",   32'(ce_v[0]),   32'd1);
        chk("mid_one_frame",       32'(dvc0),      32'(snap + 1));

        // Asynchronous reset during sclk period 10.
        pulse_start0(3'd1, t0);
        n = 0;
        while (g_adc[0].falls < 9 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_p10", 32'(g_adc[0].falls >= 9), 32'd1);
        repeat (30) @(negedge clk);
        snap = dvc0;
        #3 rst = 1'b0;
        #1;
        chk("arst_ce",   32'(ce_v[0]),       32'd1);
        chk("arst_sclk", 32'(sclk_v[0]),     32'd0);
        chk("arst_mosi", 32'(mosi_v[0]),     32'd0);
        chk("arst_busy", 32'(bus0.busy),     32'd0);
        chk("arst_data", 32'(bus0.out_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_no_dv", 32'(dvc0), 32'(snap));
        pulse_start0(3'd4, t0);
        wait_dv(0, 2000, t);
        chk("post_rst_latency", 32'(t - t0),           32'd851);
        chk("post_rst_data",    32'(bus0.out_data),    32'h07F);
        chk("post_rst_chan",    32'(bus0.out_channel), 32'd4);
        wait_idle(0, 200, tb);

        // Null bit set, data all zero.
        mnull[0] = 1'b1;
        mzero[0] = 1'b1;
        pulse_start0(3'd2, t0);
        wait_dv(0, 2000, t);
        chk("null_flag", 32'(bus0.null_err), 32'd1);
        chk("null_data", 32'(bus0.out_data), 32'h000);
        wait_idle(0, 200, tb);
        mnull[0] = 1'b0;
        mzero[0] = 1'b0;

        // Fast, differential build on channel 3.
        bus1.start   = 1'b1;
        bus1.channel = 3'd3;
        t0 = cyc;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_dv(1, 400, t);
        chk("fast_latency", 32'(t - t0),             32'd137);
        chk("fast_data",    32'(bus1.out_data),      32'h155);
        chk("fast_chan",    32'(bus1.out_channel),   32'd3);
        chk("fast_null",    32'(bus1.null_err),      32'd0);
        chk("fast_cmd",     32'(g_adc[1].bits),      32'b10011);
        chk("fast_period",  32'(g_adc[1].rise2 - g_adc[1].rise1), 32'd8);
        wait_idle(1, 100, tb);
        chk("fast_busy",    32'(tb - t0),            32'd145);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
